// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus W-cycle
// shift-add multiply and restoring divide, with valid/ready on both sides.
module seq_alu #(
  parameter int alu_op_size      = 4,
  parameter int alu_operand_size = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [alu_op_size-1:0]      alu_op,
  input  logic [2:0]                  branch,
  input  logic [alu_operand_size-1:0] op1,
  input  logic [alu_operand_size-1:0] op2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [alu_operand_size-1:0] result,
  output logic                        zero,
  output logic                        busy
);

  localparam int W  = alu_operand_size;
  localparam int SW = $clog2(W);

  localparam logic [alu_op_size-1:0] OP_AND   = alu_op_size'(0);
  localparam logic [alu_op_size-1:0] OP_OR    = alu_op_size'(1);
  localparam logic [alu_op_size-1:0] OP_XOR   = alu_op_size'(3);
  localparam logic [alu_op_size-1:0] OP_SLL   = alu_op_size'(4);
  localparam logic [alu_op_size-1:0] OP_SRL   = alu_op_size'(5);
  localparam logic [alu_op_size-1:0] OP_SUB   = alu_op_size'(6);
  localparam logic [alu_op_size-1:0] OP_SRA   = alu_op_size'(7);
  localparam logic [alu_op_size-1:0] OP_SLT   = alu_op_size'(8);
  localparam logic [alu_op_size-1:0] OP_SLTU  = alu_op_size'(9);
  localparam logic [alu_op_size-1:0] OP_MUL   = alu_op_size'(10);
  localparam logic [alu_op_size-1:0] OP_MULHU = alu_op_size'(11);
  localparam logic [alu_op_size-1:0] OP_SLLI  = alu_op_size'(12);
  localparam logic [alu_op_size-1:0] OP_SRLI  = alu_op_size'(13);
  localparam logic [alu_op_size-1:0] OP_DIVU  = alu_op_size'(14);
  localparam logic [alu_op_size-1:0] OP_REMU  = alu_op_size'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]  r_result;
  logic          r_zero;
  logic          r_zpend;
  logic          r_div;
  logic          r_sel_lo;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_b;
  logic [SW-1:0] r_cnt;

  logic          w_acc;
  logic          w_is_iter;
  logic          w_in_div;
  logic [SW-1:0] w_sh;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_fast;
  logic          w_eq;
  logic          w_slt;
  logic          w_sltu;
  logic          w_zero;
  logic [W:0]    w_madd;
  logic [W:0]    w_rsh;
  logic [W:0]    w_diff;
  logic [W-1:0]  w_nhi;
  logic [W-1:0]  w_nlo;

  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state == S_ITER);
  assign result    = r_result;
  assign zero      = r_zero;
  assign w_acc     = in_valid & in_ready;

  assign w_is_iter = (alu_op == OP_MUL) || (alu_op == OP_MULHU) ||
                     (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign w_in_div  = (alu_op == OP_DIVU) || (alu_op == OP_REMU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_is_iter ? S_ITER : S_HOLD;
      end
      S_ITER: begin
        if (r_cnt == '0) w_next = S_HOLD;
      end
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) w_next = w_is_iter ? S_ITER : S_HOLD;
          else          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sh   = op2[SW-1:0];
  assign w_sum  = op1 + op2;
  assign w_eq   = (op1 == op2);
  assign w_slt  = ($signed(op1) < $signed(op2));
  assign w_sltu = (op1 < op2);

  always_comb begin
    w_fast = w_sum;
    case (alu_op)
      OP_AND:          w_fast = op1 & op2;
      OP_OR:           w_fast = op1 | op2;
      OP_XOR:          w_fast = op1 ^ op2;
      OP_SLL, OP_SLLI: w_fast = op1 << w_sh;
      OP_SRL, OP_SRLI: w_fast = op1 >> w_sh;
      OP_SUB:          w_fast = op1 - op2;
      OP_SRA:          w_fast = W'($signed(op1) >>> w_sh);
      OP_SLT:          w_fast = W'(w_slt);
      OP_SLTU:         w_fast = W'(w_sltu);
      default:         w_fast = w_sum;
    endcase
  end

  always_comb begin
    w_zero = w_eq;
    case (branch)
      3'b001:  w_zero = ~w_eq;
      3'b010:  w_zero = 1'b1;
      3'b100:  w_zero = w_slt;
      3'b101:  w_zero = ~w_slt;
      3'b110:  w_zero = w_sltu;
      3'b111:  w_zero = ~w_sltu;
      default: w_zero = w_eq;
    endcase
  end

  // hi/lo double as product {hi,lo} for multiply and {rem,quot} for divide
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_rsh  = {r_hi, r_lo[W-1]};
  assign w_diff = w_rsh - {1'b0, r_b};

  always_comb begin
    w_nhi = w_madd[W:1];
    w_nlo = {w_madd[0], r_lo[W-1:1]};
    if (r_div) begin
      w_nhi = w_diff[W] ? w_rsh[W-1:0] : w_diff[W-1:0];
      w_nlo = {r_lo[W-2:0], ~w_diff[W]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_zpend  <= 1'b0;
      r_div    <= 1'b0;
      r_sel_lo <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
    end else if (w_acc) begin
      r_zpend <= w_zero;
      if (w_is_iter) begin
        r_div    <= w_in_div;
        r_sel_lo <= (alu_op == OP_MUL) || (alu_op == OP_DIVU);
        r_hi     <= '0;
        r_lo     <= w_in_div ? op1 : op2;
        r_b      <= w_in_div ? op2 : op1;
        r_cnt    <= SW'(W - 1);
      end else begin
        r_result <= w_fast;
        r_zero   <= w_zero;
      end
    end else if (r_state == S_ITER) begin
      r_hi <= w_nhi;
      r_lo <= w_nlo;
      if (r_cnt == '0) begin
        r_result <= r_sel_lo ? w_nlo : w_nhi;
        r_zero   <= r_zpend;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases, then randomized
// traffic with random back-pressure against an arithmetic reference model.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [2:0]  branch;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;
  int rdy_mode = 0;
  logic [32:0] exp_q[$];

  localparam logic [3:0] AND_ = 4'd0, OR_ = 4'd1, ADD_ = 4'd2, XOR_ = 4'd3;
  localparam logic [3:0] SRA_ = 4'd7, MUL_ = 4'd10, MULHU_ = 4'd11;
  localparam logic [3:0] DIVU_ = 4'd14, REMU_ = 4'd15;

  seq_alu dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .branch(branch), .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] op,
      input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        z;
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd3:  r = a ^ b;
      4'd4, 4'd12: r = a << sh;
      4'd5, 4'd13: r = a >> sh;
      4'd6:  r = a - b;
      4'd7:  r = $signed(a) >>> sh;
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd14: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd15: r = (b == 0) ? a : a % b;
      default: r = a + b;
    endcase
    case (br)
      3'd1:    z = (a != b);
      3'd2:    z = 1'b1;
      3'd4:    z = ($signed(a) < $signed(b));
      3'd5:    z = ($signed(a) >= $signed(b));
      3'd6:    z = (a < b);
      3'd7:    z = (a >= b);
      default: z = (a == b);
    endcase
    return {z, r};
  endfunction

  // monitor: pops on each output transfer, checks front while stalled
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_out: result %0h, scoreboard empty", result);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("sb_result", result, e[31:0]);
          chk("sb_zero", zero, e[32]);
        end else begin
          e = exp_q[0];
          chk("stall_result", result, e[31:0]);
          chk("stall_zero", zero, e[32]);
        end
      end
    end
  end

  task automatic set_mode(input int m);
    rdy_mode = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] br,
                       input logic [31:0] a, input logic [31:0] b,
                       output int waits, output logic ov);
    bit done;
    done  = 0;
    waits = 0;
    ov    = 1'b0;
    alu_op = op; branch = br; op1 = a; op2 = b; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        ov   = out_valid;
        exp_q.push_back(model(op, br, a, b));
      end else if (waits >= 300) begin
        done = 1;
        n_cmp++;
        n_mis++;
        $display("FAIL issue_timeout: op %0h never accepted", op);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // edges counted from the acceptance edge itself through the edge
  // that raises out_valid
  task automatic wait_out(input string nm, input logic [31:0] er,
                          input logic ez, input int ee);
    int edges;
    int bz;
    bit seen;
    edges = 1;
    bz    = 0;
    seen  = 0;
    while (!seen && edges < 100) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        if (busy) bz++;
        @(posedge clk);
        edges++;
      end
    end
    chk({nm, "_valid"}, seen, 1);
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, zero, ez);
    chk({nm, "_edges"}, edges, ee);
    chk({nm, "_busy_cycles"}, bz, ee - 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w1, w2, w3, k;
    logic v1, v2, v3;
    reset = 1'b1; in_valid = 1'b0; alu_op = '0; branch = '0;
    op1 = '0; op2 = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    set_mode(0);

    issue(ADD_, 3'b000, 32'hFFFF_FFFF, 32'd1, w1, v1);
    wait_out("add_wrap", 32'h0, 1'b0, 1);
    issue(SRA_, 3'b000, 32'h8000_0000, 32'h24, w1, v1);
    wait_out("sra", 32'hF800_0000, 1'b0, 1);
    issue(MUL_, 3'b000, 32'h0001_0000, 32'h0001_0000, w1, v1);
    wait_out("mul", 32'h0, 1'b1, 33);
    issue(MULHU_, 3'b000, 32'h0001_0000, 32'h0001_0000, w1, v1);
    wait_out("mulhu", 32'h1, 1'b1, 33);
    issue(DIVU_, 3'b000, 32'd100, 32'd0, w1, v1);
    wait_out("divu_by0", 32'hFFFF_FFFF, 1'b0, 33);
    issue(REMU_, 3'b000, 32'd100, 32'd0, w1, v1);
    wait_out("remu_by0", 32'd100, 1'b0, 33);
    issue(DIVU_, 3'b000, 32'd100, 32'd7, w1, v1);
    wait_out("divu", 32'd14, 1'b0, 33);
    issue(AND_, 3'b100, 32'hFFFF_FFFF, 32'd1, w1, v1);
    wait_out("br_slt", 32'd1, 1'b1, 1);
    issue(AND_, 3'b110, 32'hFFFF_FFFF, 32'd1, w1, v1);
    wait_out("br_sltu", 32'd1, 1'b0, 1);

    issue(XOR_, 3'b001, 32'h1234_5678, 32'h0F0F_0F0F, w1, v1);
    issue(AND_, 3'b010, 32'hDEAD_BEEF, 32'hFFFF_0000, w2, v2);
    issue(OR_, 3'b111, 32'h0000_00F0, 32'h0000_000F, w3, v3);
    chk("b2b_wait1", w1, 0);
    chk("b2b_wait2", w2, 0);
    chk("b2b_wait3", w3, 0);
    chk("b2b_valid2", v2, 1);
    chk("b2b_valid3", v3, 1);
    @(negedge clk);
    chk("b2b_valid_last", out_valid, 1);
    chk("b2b_last_result", result, 32'h0000_00FF);
    repeat (3) @(posedge clk);
    #1;

    set_mode(2);
    issue(OR_, 3'b000, 32'h0F0F_0000, 32'h0000_F0F0, w1, v1);
    repeat (4) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 32'h0F0F_F0F0);
    end
    set_mode(0);
    repeat (2) @(posedge clk);
    #1;

    issue(DIVU_, 3'b000, 32'd100, 32'd7, w1, v1);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midop_rst_valid", out_valid, 0);
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_result", result, 0);
    chk("midop_rst_zero", zero, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    issue(DIVU_, 3'b000, 32'd100, 32'd7, w1, v1);
    wait_out("divu_after_rst", 32'd14, 1'b0, 33);

    set_mode(1);
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        alu_op = 4'($urandom);
        op1    = $urandom;
        op2    = $urandom;
        @(posedge clk);
        #1;
      end
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            rv(), rv(), w1, v1);
    end

    set_mode(0);
    k = 0;
    while (exp_q.size() > 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter alu_op_size, default 4, width of the operation code.
REQ-002 The block SHALL have parameter alu_operand_size (W), default 32, operand and result width; legal values are powers of two, at least 8.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous and active-high reset.
REQ-005 Port in_valid, input, 1, request present.
REQ-006 Port in_ready, output, 1, request accepted this cycle when high together with in_valid.
REQ-007 Port alu_op, input, alu_op_size, operation code.
REQ-008 Port branch, input, 3, branch-condition select.
REQ-009 Port op1, input, W, first operand; op2, input, W, second operand.
REQ-010 Port out_valid, output, 1, result register holds an unconsumed result.
REQ-011 Port out_ready, input, 1, consumer takes result when high together with out_valid.
REQ-012 Port result, output, W, registered result; zero, output, 1, registered branch-taken flag; busy, output, 1, high while an iterative operation is in progress.

Function
REQ-013 The block SHALL implement states IDLE, ITER, HOLD.
REQ-014 in_ready SHALL be 1 in IDLE, equal to out_ready in HOLD, and 0 in ITER.
REQ-015 The block SHALL capture alu_op, branch, op1 and op2 on acceptance (in_valid && in_ready); inputs at other times SHALL be ignored.
REQ-016 Fast ops SHALL register their result on the acceptance edge and go to HOLD, so out_valid is high the cycle after acceptance: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT (signed, result 0/1), 1001 SLTU, 1100 SLLI, 1101 SRLI; all other unlisted codes SHALL be treated as ADD.
REQ-017 All shifts SHALL use only op2[log2(W)-1:0] as the shift amount; ADD, SUB and MUL SHALL wrap modulo 2^W.
REQ-018 Iterative ops SHALL go to ITER for exactly W cycles, then to HOLD: 1010 MUL (low W bits, shift-add), 1011 MULHU (high W bits of unsigned 2W product), 1110 DIVU (restoring), 1111 REMU.
REQ-019 Iterative latency SHALL be: out_valid asserted W+1 rising edges after the acceptance edge; busy SHALL be high throughout ITER.
REQ-020 DIVU with op2 == 0 SHALL return all ones, and REMU with op2 == 0 SHALL return op1, both still taking W cycles.
REQ-021 zero SHALL be computed from the captured operands, independent of alu_op, and registered with the result: 000 op1==op2, 001 op1!=op2, 010 constant 1, 100 signed op1<op2, 101 signed op1>=op2, 110 unsigned op1<op2, 111 unsigned op1>=op2, 011 same as 000.
REQ-022 In HOLD, result and zero SHALL be stable until out_ready is high.
REQ-023 In HOLD with out_ready high and no new acceptance, the block SHALL return to IDLE with out_valid 0.
REQ-024 In HOLD with out_ready and in_valid both high, the block SHALL accept the new request in the same cycle; a fast op then stays in HOLD with the new result (one result per cycle), and an iterative op goes to ITER with out_valid 0.
REQ-025 An iteration counter SHALL count W-1 down to 0; ITER SHALL exit on count 0 with no wrap.

Reset
REQ-026 While reset is high the block SHALL be in IDLE with out_valid 0, result 0, zero 0, busy 0 and counter 0, regardless of clk.
REQ-027 Reset asserted during ITER or HOLD SHALL abort the operation and discard the pending result; the first request after release SHALL be accepted normally.

Verification
REQ-028 W=32: ADD 0xFFFFFFFF+1 with branch 000 and out_ready=1 -> out_valid one cycle later, result 0x00000000, zero 0.
REQ-029 SRA 0x80000000 by op2=0x00000024 -> result 0xF8000000 (shift amount 4).
REQ-030 MUL 0x00010000*0x00010000 followed by MULHU on the same operands -> results 0x00000000 and 0x00000001, each with out_valid exactly 33 edges after acceptance and busy high for 32 cycles.
REQ-031 DIVU 100/0 and REMU 100/0 -> results 0xFFFFFFFF and 0x00000064; DIVU 100/7 -> result 14.
REQ-032 Back-to-back XOR, AND, OR with out_ready held high -> three consecutive out_valid cycles with in_ready high each cycle; with out_ready low, result holds and in_ready stays 0.
REQ-033 branch 100 with op1=0xFFFFFFFF, op2=1 -> zero 1; branch 110 with the same operands -> zero 0; reset pulse mid-DIVU -> out_valid 0, busy 0 immediately.
